// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the bitwise logic-unit arbiter.
package logic_arb_pkg;

    localparam int DATA_W = 32;

    // Saturation ceiling for the optional completed-op counter
    localparam logic [31:0] STATS_MAX = '1;

    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == STATS_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Pure combinational bitwise logic unit: (op, A, B) -> result.
// B is ignored for NOT.
module logic_op_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] not_a;

    not_gate #(
        .WIDTH(WIDTH)
    ) u_not (
        .a_i(a_i),
        .y_o(not_a)
    );

    // Select the requested bitwise function
    always_comb begin
        result_o = '0;
        case (op_e'(op_i))
            OP_NOT: result_o = not_a;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/not_gate.sv
// Bitwise inverter used by the logic unit's NOT path.
module not_gate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = ~a_i;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between N_REQ requesters.
// Flow: IDLE (grant + capture) -> EXEC (compute, register result) -> RESP
// (hold until resp_ready_i) -> IDLE.
// Optional macro LOGIC_ARB_STATS_EN adds ops_done_o, a saturating count of
// response handshakes.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = DATA_W,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [2*N_REQ-1:0]   req_op_i,
    input  logic [N_REQ*WIDTH-1:0] req_a_i,
    input  logic [N_REQ*WIDTH-1:0] req_b_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [WIDTH-1:0]     resp_data_o,
    output logic [ID_W-1:0]      resp_id_o
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [31:0]          ops_done_o
`endif
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_grant_q;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             grant_vld;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] result;

    logic [1:0]       op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    // Split the flattened request buses into per-requester fields
    always_comb begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
            op_arr[r] = req_op_i[r*2 +: 2];
            a_arr[r]  = req_a_i[r*WIDTH +: WIDTH];
            b_arr[r]  = req_b_i[r*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first valid requester after last_grant, with wrap
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_grant_q) + k) % N_REQ);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_vld)    state_d = S_EXEC;
            S_EXEC:                   state_d = S_RESP;
            S_RESP: if (resp_ready_i) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Accept strobe: one-hot in the IDLE grant cycle, suppressed while in reset
    // so no requester believes it was accepted on a dropped edge
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && grant_vld && !rst_i) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Operand capture and round-robin pointer update on the grant edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= ID_W'(N_REQ - 1);
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
        end else if (state_q == S_IDLE && grant_vld) begin
            last_grant_q <= grant_idx;
            op_q         <= op_arr[grant_idx];
            a_q          <= a_arr[grant_idx];
            b_q          <= b_arr[grant_idx];
            id_q         <= grant_idx;
        end
    end

    logic_op_unit #(
        .WIDTH(WIDTH)
    ) u_op (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .result_o(result)
    );

    // Response registers: load in EXEC, hold through RESP until handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_id_o    <= '0;
        end else begin
            case (state_q)
                S_EXEC: begin
                    resp_data_o  <= result;
                    resp_id_o    <= id_q;
                    resp_valid_o <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready_i) resp_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    // Saturating count of completed response handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ops_done_o <= '0;
        end else if (state_q == S_RESP && resp_ready_i) begin
            ops_done_o <= sat_inc32(ops_done_o);
        end
    end
`endif

endmodule
